// File: rtl/huffman_bitpacker_pkg.sv
// Shared definitions for the JPEG entropy-coder back end (jfpjc).
//   packer_state_e : bit packer control states
//   PAD_BYTE       : all-ones byte used to pad the final partial byte of a scan
package huffman_bitpacker_pkg;

  typedef enum logic [1:0] {
    PACKER_STATE_RUN   = 2'd0,
    PACKER_STATE_FLUSH = 2'd1,
    PACKER_STATE_DONE  = 2'd2
  } packer_state_e;

  localparam logic [7:0] PAD_BYTE = 8'hFF;

endpackage

// File: rtl/bitpacker_mask_align.sv
// Combinational field aligner: masks a right-justified code to len bits and
// places it in a left-aligned accumulator image directly after fill bits.
// Ports:
//   code    : right-justified bit field (bits above len ignored)
//   len     : field length, must already be limited to MAX_LEN
//   fill    : number of bits already occupied at the top of the accumulator
//   aligned : MAX_LEN+8 bit image, OR-able into the accumulator
module bitpacker_mask_align #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic [MAX_LEN-1:0]           code,
  input  logic [LEN_W-1:0]             len,
  input  logic [$clog2(MAX_LEN+8)-1:0] fill,
  output logic [MAX_LEN+7:0]           aligned
);
  localparam int ACC_W = MAX_LEN + 8;

  logic [MAX_LEN-1:0] masked;
  logic [LEN_W-1:0]   lshift;
  logic [ACC_W-1:0]   left;

  // Shifting all-ones by len==MAX_LEN yields zero, so the mask becomes all ones.
  assign masked  = code & ~({MAX_LEN{1'b1}} << len);
  // Move the field's MSB to the accumulator's top bit, then down past fill.
  assign lshift  = LEN_W'(MAX_LEN) - len;
  assign left    = {masked, 8'h00} << lshift;
  assign aligned = left >> fill;

endmodule

// File: rtl/huffman_bitpacker.sv
// Huffman bit packer: packs variable-length fields MSB-first into bytes for
// the 0xFF byte stuffer. A flush pads the last partial byte with 1s.
// Optional build macro HUFFMAN_BITPACKER_BITCOUNT_EN adds bit_count, the
// running total of accepted bits including pad bits.
// Ports:
//   clock, reset          : clock, async active-high reset
//   code_valid/code_ready : field handshake; code right-justified, code_len bits used
//   flush                 : end-of-scan request, accepted with code_ready
//   flush_done            : one-cycle pulse after the final byte
//   data_out_valid/data_out : output byte, no backpressure
module huffman_bitpacker
  import huffman_bitpacker_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               code_valid,
  input  logic [MAX_LEN-1:0] code,
  input  logic [LEN_W-1:0]   code_len,
  output logic               code_ready,
  input  logic               flush,
  output logic               flush_done,
  output logic               data_out_valid,
  output logic [7:0]         data_out
`ifdef HUFFMAN_BITPACKER_BITCOUNT_EN
  ,
  output logic [31:0]        bit_count
`endif
);
  localparam int ACC_W  = MAX_LEN + 8;
  localparam int FILL_W = $clog2(ACC_W);

  packer_state_e     state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, aligned;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [7:0]        dout_d;
  logic              dvld_d, done_d;
  logic              armed_q;
  logic [LEN_W-1:0]  len_c;
  logic              have_byte, take_code, take_flush;

`ifdef HUFFMAN_BITPACKER_BITCOUNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign bit_count = cnt_q;
`endif

  assign len_c      = (code_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : code_len;
  assign have_byte  = fill_q >= FILL_W'(8);
  // armed_q holds ready low for the first cycle after reset release.
  assign code_ready = armed_q && (state_q == PACKER_STATE_RUN) && !have_byte;
  assign take_code  = code_ready && code_valid;
  assign take_flush = code_ready && flush;

  bitpacker_mask_align #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_align (
    .code    (code),
    .len     (len_c),
    .fill    (fill_q),
    .aligned (aligned)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    dout_d  = data_out;
    dvld_d  = 1'b0;
    done_d  = 1'b0;
`ifdef HUFFMAN_BITPACKER_BITCOUNT_EN
    cnt_d   = cnt_q;
`endif
    if (have_byte) begin
      // Draining a full byte always wins, in any state.
      dout_d = acc_q[ACC_W-1 -: 8];
      dvld_d = 1'b1;
      acc_d  = acc_q << 8;
      fill_d = fill_q - FILL_W'(8);
    end else begin
      unique case (state_q)
        PACKER_STATE_RUN: begin
          if (take_code) begin
            acc_d  = acc_q | aligned;
            fill_d = fill_q + FILL_W'(len_c);
`ifdef HUFFMAN_BITPACKER_BITCOUNT_EN
            cnt_d  = cnt_q + 32'(len_c);
`endif
          end
          // A same-cycle code is appended before the flush takes effect.
          if (take_flush) state_d = PACKER_STATE_FLUSH;
        end
        PACKER_STATE_FLUSH: begin
          if (fill_q != '0) begin
            // Unused low bits of the accumulator are zero, so OR in the pad.
            dout_d = acc_q[ACC_W-1 -: 8] | (PAD_BYTE >> fill_q);
            dvld_d = 1'b1;
            acc_d  = '0;
            fill_d = '0;
`ifdef HUFFMAN_BITPACKER_BITCOUNT_EN
            cnt_d  = cnt_q + 32'(FILL_W'(8) - fill_q);
`endif
          end else begin
            state_d = PACKER_STATE_DONE;
            done_d  = 1'b1;
          end
        end
        PACKER_STATE_DONE: state_d = PACKER_STATE_RUN;
        default:           state_d = PACKER_STATE_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= PACKER_STATE_RUN;
      acc_q          <= '0;
      fill_q         <= '0;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      flush_done     <= 1'b0;
      armed_q        <= 1'b0;
`ifdef HUFFMAN_BITPACKER_BITCOUNT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      fill_q         <= fill_d;
      data_out       <= dout_d;
      data_out_valid <= dvld_d;
      flush_done     <= done_d;
      armed_q        <= 1'b1;
`ifdef HUFFMAN_BITPACKER_BITCOUNT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

endmodule
